// File: rtl/uart_frame_rx.sv
// Drains the UART RX FIFO and reassembles 4-byte remote-player frames
// (sync, header, Y low byte, XOR checksum) for the two-board ping-pong game.
module uart_frame_rx #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter logic [9:0]  Y_MAX        = 10'd479,
    parameter logic [9:0]  Y_INIT       = 10'd204,
    parameter int unsigned BYTE_TIMEOUT = 500_000,
    parameter int unsigned LINK_TIMEOUT = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_empty,
    input  logic [7:0] rd_data,
    output logic       rd_uart,
    output logic [9:0] paddle_y,
    output logic [1:0] buttons,
    output logic       frame_tick,
    output logic       chk_err,
    output logic       link_up,
    output logic [7:0] err_count
);

    localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
    localparam int LT_W = $clog2(LINK_TIMEOUT + 1);

    typedef enum logic [1:0] {HUNT, HDR, LO, CHK} state_t;

    state_t          state, state_next;
    logic [7:0]      b1_q, b2_q;
    logic [BT_W-1:0] byte_cnt;
    logic [LT_W-1:0] link_cnt;

    logic       pop;
    logic       byte_expire;
    logic       frame_err, sum_err, accept, latch_b1, latch_b2;
    logic       err_event;
    logic [9:0] y_raw, y_clamped;

    // The FIFO head is consumed in the same cycle it is presented.
    assign pop     = ~rx_empty & ~reset;
    assign rd_uart = pop;

    // A popped byte always pre-empts a timeout in the same cycle.
    assign byte_expire = (state != HUNT) && !pop &&
                         (byte_cnt == BT_W'(BYTE_TIMEOUT - 1));

    assign y_raw     = {b1_q[1:0], b2_q};
    assign y_clamped = (y_raw > Y_MAX) ? Y_MAX : y_raw;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        frame_err  = 1'b0;
        sum_err    = 1'b0;
        accept     = 1'b0;
        latch_b1   = 1'b0;
        latch_b2   = 1'b0;
        if (pop) begin
            unique case (state)
                HUNT: if (rd_data == SYNC_BYTE) state_next = HDR;
                HDR: begin
                    if (rd_data[5:2] != 4'b0000) begin
                        frame_err  = 1'b1;
                        state_next = (rd_data == SYNC_BYTE) ? HDR : HUNT;
                    end else begin
                        latch_b1   = 1'b1;
                        state_next = LO;
                    end
                end
                LO: begin
                    latch_b2   = 1'b1;
                    state_next = CHK;
                end
                CHK: begin
                    if (rd_data == (b1_q ^ b2_q)) accept  = 1'b1;
                    else                          sum_err = 1'b1;
                    state_next = HUNT;
                end
                default: state_next = HUNT;
            endcase
        end else if (byte_expire) begin
            state_next = HUNT;
        end
    end

    assign err_event = frame_err | sum_err | byte_expire;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HUNT;
            b1_q       <= 8'h00;
            b2_q       <= 8'h00;
            byte_cnt   <= '0;
            link_cnt   <= '0;
            paddle_y   <= Y_INIT;
            buttons    <= 2'b00;
            frame_tick <= 1'b0;
            chk_err    <= 1'b0;
            link_up    <= 1'b0;
            err_count  <= 8'h00;
        end else begin
            state      <= state_next;
            frame_tick <= accept;
            chk_err    <= sum_err;

            if (latch_b1) b1_q <= rd_data;
            if (latch_b2) b2_q <= rd_data;

            if (pop || state == HUNT || byte_expire) byte_cnt <= '0;
            else                                     byte_cnt <= byte_cnt + BT_W'(1);

            if (accept) begin
                paddle_y <= y_clamped;
                buttons  <= b1_q[7:6];
            end

            // Accept beats expiry; otherwise the counter stops at the limit.
            if (accept) begin
                link_cnt <= '0;
                link_up  <= 1'b1;
            end else if (link_cnt != LT_W'(LINK_TIMEOUT)) begin
                link_cnt <= link_cnt + LT_W'(1);
                if (link_cnt == LT_W'(LINK_TIMEOUT - 1)) link_up <= 1'b0;
            end

            if (err_event && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: directed frames plus a randomized
// byte stream compared every cycle against a frame-level reference model.
module tb_uart_frame_rx;

    localparam int BT = 16;
    localparam int LT = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_empty;
    logic [7:0] rd_data;
    logic       rd_uart;
    logic [9:0] paddle_y;
    logic [1:0] buttons;
    logic       frame_tick;
    logic       chk_err;
    logic       link_up;
    logic [7:0] err_count;

    uart_frame_rx #(
        .SYNC_BYTE   (8'hA5),
        .Y_MAX       (10'd479),
        .Y_INIT      (10'd204),
        .BYTE_TIMEOUT(BT),
        .LINK_TIMEOUT(LT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_empty  (rx_empty),
        .rd_data   (rd_data),
        .rd_uart   (rd_uart),
        .paddle_y  (paddle_y),
        .buttons   (buttons),
        .frame_tick(frame_tick),
        .chk_err   (chk_err),
        .link_up   (link_up),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ticks  = 0;
    int n_chk    = 0;

    // Reference model: bytes gathered so far in the current frame and
    // the ages of the byte gap and of the last good frame.
    int         m_len, m_idle, m_age;
    logic [7:0] m_b1, m_b2, m_err;
    logic [9:0] m_y;
    logic [1:0] m_btn;
    logic       m_tick, m_chk, m_up;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic empty, input logic [7:0] b);
        logic       err;
        logic       acc;
        logic [9:0] y;
        if (rst) begin
            m_len = 0; m_idle = 0; m_age = 0; m_b1 = 0; m_b2 = 0; m_err = 0;
            m_y = 10'd204; m_btn = 0; m_tick = 0; m_chk = 0; m_up = 0;
            return;
        end
        err = 0; acc = 0; m_tick = 0; m_chk = 0;
        if (!empty) begin
            m_idle = 0;
            if (m_len == 0) begin
                if (b == 8'hA5) m_len = 1;
            end else if (m_len == 1) begin
                if ((b & 8'h3C) != 0) begin
                    err = 1;
                    m_len = (b == 8'hA5) ? 1 : 0;
                end else begin
                    m_b1 = b; m_len = 2;
                end
            end else if (m_len == 2) begin
                m_b2 = b; m_len = 3;
            end else begin
                if (b == (m_b1 ^ m_b2)) acc = 1;
                else begin err = 1; m_chk = 1; end
                m_len = 0;
            end
        end else if (m_len != 0) begin
            m_idle++;
            if (m_idle == BT) begin err = 1; m_len = 0; m_idle = 0; end
        end
        if (acc) begin
            y = {m_b1[1:0], m_b2};
            m_y = (y > 10'd479) ? 10'd479 : y;
            m_btn = m_b1[7:6]; m_tick = 1; m_up = 1; m_age = 0;
        end else if (m_age < LT) begin
            m_age++;
            if (m_age == LT) m_up = 0;
        end
        if (err && m_err != 8'hFF) m_err = m_err + 8'd1;
    endtask

    // Presents one cycle of FIFO state; called and returns at a falling edge.
    task automatic step(input logic empty, input logic [7:0] b);
        rx_empty = empty;
        rd_data  = b;
        #1;
        check("rd_uart", 32'(rd_uart), 32'(!empty && !reset));
        @(posedge clk);
        model_step(reset, empty, b);
        @(negedge clk);
        check("paddle_y", 32'(paddle_y), 32'(m_y));
        check("buttons", 32'(buttons), 32'(m_btn));
        check("frame_tick", 32'(frame_tick), 32'(m_tick));
        check("chk_err", 32'(chk_err), 32'(m_chk));
        check("link_up", 32'(link_up), 32'(m_up));
        check("err_count", 32'(err_count), 32'(m_err));
        if (frame_tick) n_ticks++;
        if (chk_err) n_chk++;
    endtask

    task automatic tx(input logic [7:0] b);
        step(1'b0, b);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 8'($urandom));
    endtask

    initial begin
        int e0, t0, c0;
        logic [9:0] ry;
        logic [1:0] rb;
        logic [7:0] fr [4];

        reset = 1'b1; rx_empty = 1'b1; rd_data = 8'h00;
        @(negedge clk);
        tx(8'hA5); tx(8'h41);
        reset = 1'b0;
        check("rst_paddle_y", 32'(paddle_y), 32'd204);
        check("rst_buttons", 32'(buttons), 32'd0);
        check("rst_link_up", 32'(link_up), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        idle(2);

        // Basic frame: y=300, buttons=01.
        t0 = n_ticks;
        tx(8'hA5); tx(8'h41); tx(8'h2C); tx(8'h6D);
        check("t1_y", 32'(paddle_y), 32'd300);
        check("t1_btn", 32'(buttons), 32'd1);
        check("t1_link", 32'(link_up), 32'd1);
        check("t1_err", 32'(err_count), 32'd0);
        idle(3);
        check("t1_ticks", 32'(n_ticks - t0), 32'd1);

        // y=1000 clamps to Y_MAX.
        tx(8'hA5); tx(8'h03); tx(8'hE8); tx(8'hEB);
        check("t2_tick", 32'(frame_tick), 32'd1);
        check("t2_y", 32'(paddle_y), 32'd479);
        check("t2_btn", 32'(buttons), 32'd0);

        // Bad checksum, then resync.
        c0 = n_chk;
        tx(8'hA5); tx(8'h41); tx(8'h2C); tx(8'h00);
        idle(1);
        check("t3_chk_pulses", 32'(n_chk - c0), 32'd1);
        check("t3_err", 32'(err_count), 32'd1);
        check("t3_y_kept", 32'(paddle_y), 32'd479);
        tx(8'h00); tx(8'hA5); tx(8'h41); tx(8'h2C); tx(8'h6D);
        check("t3_y_new", 32'(paddle_y), 32'd300);
        check("t3_err_after", 32'(err_count), 32'd1);

        // Junk byte then doubled sync.
        e0 = int'(err_count); t0 = n_ticks;
        tx(8'h5A); tx(8'hA5); tx(8'hA5); tx(8'h41); tx(8'h2C); tx(8'h6D);
        check("t4_err", 32'(err_count), 32'(e0 + 1));
        check("t4_ticks", 32'(n_ticks - t0), 32'd1);

        // Byte timeout in mid-frame.
        tx(8'hA5); tx(8'h03); tx(8'hE8); tx(8'hEB);
        e0 = int'(err_count); t0 = n_ticks;
        tx(8'hA5); tx(8'h41);
        idle(BT - 1);
        check("t5_err_before", 32'(err_count), 32'(e0));
        idle(1);
        check("t5_err_after", 32'(err_count), 32'(e0 + 1));
        tx(8'h2C); tx(8'h6D);
        check("t5_ticks", 32'(n_ticks - t0), 32'd0);
        check("t5_y", 32'(paddle_y), 32'd479);

        // Reset in the middle of a frame.
        tx(8'hA5); tx(8'h41);
        reset = 1'b1; tx(8'h2C); reset = 1'b0;
        t0 = n_ticks;
        tx(8'h2C); tx(8'h6D);
        check("t6_err", 32'(err_count), 32'd0);
        check("t6_y", 32'(paddle_y), 32'd204);
        check("t6_ticks", 32'(n_ticks - t0), 32'd0);

        // Link liveness window.
        tx(8'hA5); tx(8'h41); tx(8'h2C); tx(8'h6D);
        check("t7_tick", 32'(frame_tick), 32'd1);
        for (int k = 1; k <= LT + 5; k++) begin
            idle(1);
            if (k == LT - 1) check("t7_link_99", 32'(link_up), 32'd1);
            if (k == LT)     check("t7_link_100", 32'(link_up), 32'd0);
        end

        // Error counter saturation.
        for (int i = 0; i < 300; i++) begin
            tx(8'hA5); tx(8'h41); tx(8'h2C); tx(8'h00);
        end
        check("t8_err_sat", 32'(err_count), 32'd255);

        reset = 1'b1; idle(1); reset = 1'b0;

        // Randomized stream: valid, corrupted and junk-prefixed frames with gaps.
        for (int f = 0; f < 400; f++) begin
            ry = 10'($urandom);
            rb = 2'($urandom);
            fr[0] = 8'hA5;
            fr[1] = {rb, 4'b0000, ry[9:8]};
            fr[2] = ry[7:0];
            fr[3] = fr[1] ^ fr[2];
            case ($urandom_range(0, 15))
                0: fr[1] = fr[1] ^ (8'h04 << $urandom_range(0, 3));
                1: fr[3] = fr[3] ^ 8'($urandom_range(1, 255));
                2: tx(8'($urandom));
                3: idle($urandom_range(LT, LT + 20));
                default: ;
            endcase
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 9) == 0) idle($urandom_range(1, BT + 4));
                tx(fr[i]);
            end
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Receive-side frame decoder that drains the UART receive FIFO (pop interface: `rx_empty`, `rd_data`, `rd_uart`) and reassembles 4-byte remote-player frames for the two-board ping-pong game. It validates sync, reserved bits and checksum, clamps the paddle position, and publishes the remote paddle Y and buttons to the game logic. It also reports error statistics and link liveness.

## Interface
- `SYNC_BYTE`, 8'hA5, frame start marker
- `Y_MAX`, 10'd479, largest legal paddle Y; larger values clamp to this
- `Y_INIT`, 10'd204, `paddle_y` value after reset
- `BYTE_TIMEOUT`, 500_000, idle cycles allowed between bytes inside a frame
- `LINK_TIMEOUT`, 5_000_000, cycles without a valid frame before `link_up` drops
- `clk`  in  1  system clock; the only clock
- `reset`  in  1  synchronous, active-high reset
- `rx_empty`  in  1  UART RX FIFO empty
- `rd_data`  in  8  UART RX FIFO head byte, valid whenever `rx_empty`=0
- `rd_uart`  out  1  FIFO pop strobe
- `paddle_y`  out  10  remote paddle Y (registered)
- `buttons`  out  2  remote buttons (registered)
- `frame_tick`  out  1  one-cycle pulse when a frame is accepted
- `chk_err`  out  1  one-cycle pulse on a checksum mismatch
- `link_up`  out  1  a valid frame arrived within the last `LINK_TIMEOUT` cycles
- `err_count`  out  8  saturating count of all frame errors

## Operation
- Frame format, in order:
  - B0 = `SYNC_BYTE`
  - B1 = {btn[1:0], 4'b0000, y[9:8]}
  - B2 = y[7:0]
  - B3 = B1 ^ B2
- Pop rule: `rd_uart` = ~`rx_empty` & ~`reset`. The byte is consumed in the same cycle as `rd_data`. Exactly one byte is consumed per cycle with `rd_uart`=1.
- FSM states: HUNT, HDR, LO, CHK. Reset state is HUNT.
- HUNT: a byte equal to `SYNC_BYTE` moves to HDR. Any other byte is discarded with no error.
- HDR: if B1[5:2]≠0, count a framing error. The next state is HDR if the byte equals `SYNC_BYTE`, otherwise HUNT. Otherwise latch B1 and go to LO.
- LO: latch B2 and go to CHK.
- CHK: if the byte equals B1^B2, accept the frame. Otherwise pulse `chk_err`, count an error, and return to HUNT. After a good checksum, the next state is HUNT.
- Accept:
  - `paddle_y` ← min({B1[1:0],B2}, `Y_MAX`)
  - `buttons` ← B1[7:6]
  - pulse `frame_tick`
  - set `link_up`
  - reload the link timer
- Inter-byte timer:
  - counts every cycle while in HDR, LO or CHK with no byte popped
  - cleared on every pop and in HUNT
  - on reaching `BYTE_TIMEOUT`: count an error, go to HUNT, discard the partial frame
- Link timer:
  - counts every cycle
  - reloaded on each accepted frame
  - on reaching `LINK_TIMEOUT`: clear `link_up` and hold the count (no wrap)
- `err_count` increments by 1 on a framing error, checksum error or byte timeout, and saturates at 8'hFF. At most one error event can occur per cycle.
- Rejected frames leave `paddle_y` and `buttons` unchanged.

## Timing
- Reset values: `rd_uart` 0, `paddle_y` `Y_INIT`, `buttons` 0, `frame_tick` 0, `chk_err` 0, `link_up` 0, `err_count` 0. Both timers are 0 and the FSM is in HUNT.
- Reset asserted mid-frame aborts the frame on the next edge with no error counted.
- Latency: outputs update on the clock edge that pops B3. `frame_tick` is high for exactly that following cycle, and `paddle_y` is already new in that cycle.
- Back-to-back frames with a non-empty FIFO: 4 cycles per frame, and `frame_tick` may pulse every 4th cycle.
- A byte pop and a timeout in the same cycle: the byte wins, is processed, and the timer clears.
- An accepted frame and link-timer expiry in the same cycle: the accept wins and `link_up` stays 1.
- The FIFO ignores `rd_uart` when empty. The block never asserts `rd_uart` while `rx_empty`=1.

## Test plan
- Reset, then FIFO supplies A5 41 2C 6D -> four consecutive pops; `paddle_y`=300, `buttons`=2'b01, a single `frame_tick`, `link_up`=1, `err_count`=0.
- A5 03 E8 EB (y=1000) -> `paddle_y`=479 (clamped), `buttons`=0, `frame_tick` pulses.
- A5 41 2C 00 -> `chk_err` pulses once, `err_count`=1, `paddle_y` unchanged; then 00 A5 41 2C 6D is accepted with no further error.
- 5A A5 A5 41 2C 6D -> 5A is discarded silently; the second A5 is a framing error that stays in HDR; the frame is accepted and `err_count`=1.
- `BYTE_TIMEOUT`=16: A5 41, then FIFO empty for 16 cycles -> `err_count`+1 and HUNT; a later 2C 6D is discarded; `paddle_y` unchanged.
- `LINK_TIMEOUT`=100: one valid frame, then silence -> `link_up` is 1 through cycle 99 after `frame_tick` and 0 from cycle 100. Also force 300 bad frames -> `err_count` holds at 255.
